// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment driver:
// active-low segment patterns for hex digits and the "all off" codes.
package seg_scan_driver_pkg;

  // Slot index: 0 drives the rightmost digit, 3 the leftmost.
  typedef logic [1:0] slot_t;

  // Segment code with every segment dark (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode code with every digit dark (anodes are active-low).
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Hex-to-segment table, {g,f,e,d,c,b,a}, active-low, indexed by digit value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg_scan_driver_seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern decoder.
module seg7_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Straight table lookup; every 4-bit value has a defined pattern.
  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-scan input
// snapshot, leading-zero blanking, decimal points and whole-display blink.
// All display outputs come straight from flops, so a slot change moves the
// single low anode in one edge and never shows two digits lit at once.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CNT_MAX     = 100000,
  parameter int BLINK_SCANS = 128
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dig4,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(CNT_MAX);
  localparam int SW = $clog2(BLINK_SCANS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_MAX - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(BLINK_SCANS - 1);

  // Scan timing state.
  logic [PW-1:0] presc_r;
  slot_t         slot_r;
  logic [SW-1:0] scan_r;
  logic          phase_r;

  // Snapshot of the inputs, taken once per full scan; index 0 = dig4.
  logic [3:0][3:0] sh_dig_r;
  logic [3:0]      sh_dp_r;
  logic            sh_blz_r;
  logic            sh_blink_r;

  // Snapshot as seen by this cycle's output computation.
  logic            load_s;
  logic [3:0][3:0] eff_dig_s;
  logic [3:0]      eff_dp_s;
  logic            eff_blz_s;
  logic            eff_blink_s;

  logic [3:0] cur_dig_s;
  logic [6:0] dec_seg_s;
  logic       lz_s;
  logic [3:0] an_s;
  logic [6:0] seg_s;
  logic       dp_s;

  logic [3:0] an_r;
  logic [6:0] seg_r;
  logic       dp_r;

  // The snapshot is refreshed at the start of every scan (slot 0, count 0).
  assign load_s = (presc_r == '0) && (slot_r == 2'd0);

  // Prescaler, slot, and blink phase counters; all wrap silently.
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_r <= '0;
      slot_r  <= 2'd0;
      scan_r  <= '0;
      phase_r <= 1'b0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      slot_r  <= slot_r + 2'd1;
      if (slot_r == 2'd3) begin
        if (scan_r == SCAN_LAST) begin
          scan_r  <= '0;
          phase_r <= ~phase_r;
        end else begin
          scan_r <= scan_r + SW'(1);
        end
      end
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Shadow registers: capture all display inputs at the start of each scan.
  always_ff @(posedge clk) begin
    if (clr) begin
      sh_dig_r   <= '0;
      sh_dp_r    <= 4'b0000;
      sh_blz_r   <= 1'b0;
      sh_blink_r <= 1'b0;
    end else if (load_s) begin
      sh_dig_r   <= {dig1, dig2, dig3, dig4};
      sh_dp_r    <= dp_in;
      sh_blz_r   <= blank_lz;
      sh_blink_r <= blink;
    end
  end

  // On the load cycle use the incoming values so the whole scan, including
  // its first slot-0 output, comes from a single consistent snapshot.
  always_comb begin
    if (load_s) begin
      eff_dig_s   = {dig1, dig2, dig3, dig4};
      eff_dp_s    = dp_in;
      eff_blz_s   = blank_lz;
      eff_blink_s = blink;
    end else begin
      eff_dig_s   = sh_dig_r;
      eff_dp_s    = sh_dp_r;
      eff_blz_s   = sh_blz_r;
      eff_blink_s = sh_blink_r;
    end
  end

  assign cur_dig_s = eff_dig_s[slot_r];

  seg7_hex_decode u_dec (
    .hex (cur_dig_s),
    .seg (dec_seg_s)
  );

  // A digit is a leading zero when it and every digit to its left are zero;
  // the rightmost digit is always shown.
  always_comb begin
    lz_s = 1'b0;
    case (slot_r)
      2'd3:    lz_s = (eff_dig_s[3] == 4'd0);
      2'd2:    lz_s = (eff_dig_s[3] == 4'd0) && (eff_dig_s[2] == 4'd0);
      2'd1:    lz_s = (eff_dig_s[3] == 4'd0) && (eff_dig_s[2] == 4'd0) &&
                      (eff_dig_s[1] == 4'd0);
      2'd0:    lz_s = 1'b0;
      default: lz_s = 1'b0;
    endcase
  end

  // Next display values: one anode low unless the blink off-phase darkens all.
  always_comb begin
    an_s         = AN_OFF;
    an_s[slot_r] = 1'b0;
    if (eff_blink_s && phase_r) begin
      an_s = AN_OFF;
    end else begin
      an_s = an_s;
    end
    if (eff_blz_s && lz_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = dec_seg_s;
    end
    dp_s = ~eff_dp_s[slot_r];
  end

  // Output registers; reset forces the whole display dark.
  always_ff @(posedge clk) begin
    if (clr) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule
